// File: rtl/isa_io_cycle_initiator_pkg.sv
// Shared definitions for the ISA I/O cycle initiator: FSM state encoding,
// default bus timing, the accepted I/O address window and phase-timer helpers.
package isa_io_cycle_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_HOLD,
        ST_RECOVER
    } isa_state_t;

    // Phase timer width; must hold WAIT_TIMEOUT-1
    localparam int CNT_W = 8;

    localparam logic [9:0] DEF_ADDR_BASE      = 10'h100;
    localparam logic [9:0] DEF_ADDR_LAST      = 10'h13E;
    localparam int         DEF_ALE_CYCLES     = 1;
    localparam int         DEF_SETUP_CYCLES   = 1;
    localparam int         DEF_STROBE_CYCLES  = 4;
    localparam int         DEF_HOLD_CYCLES    = 1;
    localparam int         DEF_RECOVERY_CYCLES = 2;
    localparam int         DEF_WAIT_TIMEOUT   = 64;

    // A phase lasting n cycles loads n-1 so that done rises in its last cycle;
    // anything shorter than one cycle is stretched to one.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        if (cycles <= 1)
            return '0;
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/isa_io_cycle_initiator_phase_timer.sv
// Loadable down-counter shared by every bus phase. done is high while the
// count is zero, i.e. in the last cycle of the phase that loaded it.
module isa_io_cycle_initiator_phase_timer
    import isa_io_cycle_initiator_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/isa_io_cycle_initiator.sv
// ISA host-side I/O cycle generator. Accepts one command at a time, runs a
// single 8-bit IOR/IOW cycle with ALE/setup/strobe/hold/recovery phasing,
// stretches the strobe while CHRDY is low (bounded by WAIT_TIMEOUT) and
// returns read data plus timeout/error status as a one-cycle response.
// The bidirectional data bus is resolved above this block via isa_data_oe.
module isa_io_cycle_initiator
    import isa_io_cycle_initiator_pkg::*;
#(
    parameter logic [9:0] ADDR_BASE       = DEF_ADDR_BASE,
    parameter logic [9:0] ADDR_LAST       = DEF_ADDR_LAST,
    parameter int         ALE_CYCLES      = DEF_ALE_CYCLES,
    parameter int         SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int         STROBE_CYCLES   = DEF_STROBE_CYCLES,
    parameter int         HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int         RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int         WAIT_TIMEOUT    = DEF_WAIT_TIMEOUT
) (
    input  logic       isa_clk,
    input  logic       isa_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       rsp_error,
    output logic [9:0] isa_addr,
    output logic       isa_ale,
    output logic       isa_aen,
    output logic       isa_ior,
    output logic       isa_iow,
    input  logic       isa_chrdy,
    output logic [7:0] isa_data_out,
    output logic       isa_data_oe,
    input  logic [7:0] isa_data_in
);

    isa_state_t       state;
    logic             accept;
    logic             addr_ok;
    logic             strobe_exit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    // Latched command and captured bus data (datapath, no reset needed)
    logic             wr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_cap;

    // Per-command status flags, published at completion
    logic             err_q;
    logic             to_q;

    assign accept  = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign addr_ok = (cmd_addr >= ADDR_BASE) && (cmd_addr <= ADDR_LAST);

    // The strobe ends either on time with CHRDY high, or out of WAIT on
    // CHRDY returning high or the timeout running out.
    assign strobe_exit = ((state == ST_STROBE) && tmr_done && isa_chrdy) ||
                         ((state == ST_WAIT) && (isa_chrdy || tmr_done));

    // Only I/O cycles are generated, never DMA
    assign isa_aen = 1'b0;

    isa_io_cycle_initiator_phase_timer u_timer (
        .clk      (isa_clk),
        .rst_n    (isa_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Load the phase timer on the edge that enters each new phase
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = addr_ok ? phase_load(ALE_CYCLES) : phase_load(RECOVERY_CYCLES);
                end
            end
            ST_ALE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(STROBE_CYCLES);
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = isa_chrdy ? phase_load(HOLD_CYCLES) : phase_load(WAIT_TIMEOUT);
                end
            end
            ST_WAIT: begin
                if (strobe_exit) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(RECOVERY_CYCLES);
                end
            end
            default: ;
        endcase
    end

    // Capture the command on accept and the read data on the strobe exit edge
    always_ff @(posedge isa_clk) begin
        if (accept) begin
            wr_q    <= cmd_write;
            wdata_q <= cmd_wdata;
        end
        if (strobe_exit)
            rdata_cap <= isa_data_in;
    end

    // Bus-cycle FSM with registered bus and response outputs
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
            rsp_error    <= 1'b0;
            isa_addr     <= '0;
            isa_ale      <= 1'b0;
            isa_ior      <= 1'b1;
            isa_iow      <= 1'b1;
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
            err_q        <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        to_q      <= 1'b0;
                        if (addr_ok) begin
                            err_q    <= 1'b0;
                            isa_addr <= cmd_addr;
                            isa_ale  <= 1'b1;
                            state    <= ST_ALE;
                        end else begin
                            // Out-of-window: leave the bus alone, just respond
                            err_q <= 1'b1;
                            state <= ST_RECOVER;
                        end
                    end
                end
                ST_ALE: begin
                    if (tmr_done) begin
                        isa_ale <= 1'b0;
                        state   <= ST_SETUP;
                        if (wr_q) begin
                            isa_data_oe  <= 1'b1;
                            isa_data_out <= wdata_q;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        if (wr_q)
                            isa_iow <= 1'b0;
                        else
                            isa_ior <= 1'b0;
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        if (isa_chrdy) begin
                            isa_ior <= 1'b1;
                            isa_iow <= 1'b1;
                            state   <= ST_HOLD;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (strobe_exit) begin
                        isa_ior <= 1'b1;
                        isa_iow <= 1'b1;
                        to_q    <= !isa_chrdy;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        isa_data_oe <= 1'b0;
                        state       <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (tmr_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_error   <= err_q;
                        rsp_timeout <= to_q;
                        // Read data only changes when a read actually ran on the bus
                        if (!wr_q && !err_q)
                            rsp_rdata <= rdata_cap;
                        cmd_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
